// File: rtl/pipe_pkg.sv
// Shared defaults and control-field layout for the pipeline stage register.
// Optional skid entry is enabled with the PIPE_STAGE_SKID_EN macro.
package pipe_pkg;

    localparam int PIPE_DATA_W = 111;
    localparam int PIPE_CTRL_W = 8;

    // Control bundle layout: WB in the top bits, then M, then EX.
    localparam int CTRL_WB_OFF = 6;
    localparam int CTRL_WB_W   = 2;
    localparam int CTRL_M_OFF  = 3;
    localparam int CTRL_M_W    = 3;
    localparam int CTRL_EX_OFF = 0;
    localparam int CTRL_EX_W   = 3;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_IN     = 2'd1,
        SEL_SKID   = 2'd2,
        SEL_BUBBLE = 2'd3
    } out_sel_e;

    function automatic logic [CTRL_WB_W-1:0] ctrl_wb(input logic [PIPE_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_WB_OFF +: CTRL_WB_W];
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second holding entry that catches a beat accepted while the output register
// is stalled by downstream back-pressure.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Skid entry state; load and drain are never asserted together by the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= ctrl_in;
            data_r  <= data_in;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign ctrl  = ctrl_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall, flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN to add a skid entry that decouples ready_o from ready_i.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    logic              skid_valid_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;

    logic              main_open_s;
    logic              ready_s;
    logic              in_xfer_s;
    out_sel_e          sel_s;

    // Output register is free when empty or its beat leaves this cycle.
    assign main_open_s = !valid_r || ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic skid_load_s;
    logic skid_drain_s;

    assign ready_s      = !rst_i && !stall_i && !skid_valid_s;
    assign in_xfer_s    = valid_i && ready_s;
    assign skid_load_s  = in_xfer_s && !main_open_s;
    assign skid_drain_s = skid_valid_s && main_open_s;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (flush_i),
        .load    (skid_load_s),
        .drain   (skid_drain_s),
        .ctrl_in (ctrl_i),
        .data_in (data_i),
        .valid   (skid_valid_s),
        .ctrl    (skid_ctrl_s),
        .data    (skid_data_s)
    );

    assign count_o = {1'b0, valid_r} + {1'b0, skid_valid_s};
`else
    assign ready_s      = !rst_i && !stall_i && main_open_s;
    assign in_xfer_s    = valid_i && ready_s;
    assign skid_valid_s = 1'b0;
    assign skid_ctrl_s  = '0;
    assign skid_data_s  = '0;
    assign count_o      = {1'b0, valid_r};
`endif

    // Choose what the output register takes next; the skid beat is older than any input.
    always_comb begin
        sel_s = SEL_HOLD;
        if (main_open_s && skid_valid_s) begin
            sel_s = SEL_SKID;
        end else if (main_open_s && in_xfer_s) begin
            sel_s = SEL_IN;
        end else if (main_open_s) begin
            sel_s = SEL_BUBBLE;
        end else begin
            sel_s = SEL_HOLD;
        end
    end

    // Output register; a bubble clears control but keeps the last payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
        end else begin
            case (sel_s)
                SEL_SKID: begin
                    valid_r <= 1'b1;
                    ctrl_r  <= skid_ctrl_s;
                    data_r  <= skid_data_s;
                end
                SEL_IN: begin
                    valid_r <= 1'b1;
                    ctrl_r  <= ctrl_i;
                    data_r  <= data_i;
                end
                SEL_BUBBLE: begin
                    valid_r <= 1'b0;
                    ctrl_r  <= '0;
                end
                SEL_HOLD: begin
                    valid_r <= valid_r;
                end
                default: begin
                    valid_r <= valid_r;
                end
            endcase
        end
    end

    assign ready_o = ready_s;
    assign valid_o = valid_r;
    assign ctrl_o  = ctrl_r;
    assign data_o  = data_r;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 111: payload width (RS data, RT data, sign-extend, RS/RT/RD addresses).
REQ-002 Parameter CTRL_W, default 8: control-field width (WB, M, EX bundles).
REQ-003 Port clk_i  in  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  in  1: reset; synchronous, active-high.
REQ-005 Port stall_i  in  1: hazard hold; blocks input acceptance.
REQ-006 Port flush_i  in  1: discard all held entries and insert a bubble.
REQ-007 Port valid_i  in  1: upstream beat valid.
REQ-008 Port ready_o  out  1: stage can accept a beat this cycle.
REQ-009 Port ctrl_i  in  CTRL_W: upstream control fields.
REQ-010 Port data_i  in  DATA_W: upstream payload.
REQ-011 Port valid_o  out  1: downstream beat valid.
REQ-012 Port ready_i  in  1: downstream accepts the beat.
REQ-013 Port ctrl_o  out  CTRL_W: registered control fields.
REQ-014 Port data_o  out  DATA_W: registered payload.
REQ-015 Port count_o  out  2: entries held, 0..2 (0..1 without skid).

Function
REQ-016 Input transfer SHALL occur when valid_i && ready_o; output transfer SHALL occur when valid_o && ready_i.
REQ-017 An accepted beat SHALL appear on valid_o/ctrl_o/data_o exactly one cycle later when the stage is empty or draining.
REQ-018 While valid_o=0, ctrl_o SHALL be all-zero (bubble); data_o SHALL hold its last value.
REQ-019 While valid_o=1 and ready_i=0, valid_o, ctrl_o and data_o SHALL remain stable.
REQ-020 stall_i=1 SHALL force ready_o=0; held entries SHALL still drain to downstream on ready_i.
REQ-021 flush_i=1 SHALL, on the next edge, set count_o=0, valid_o=0, ctrl_o=0; any same-cycle input or output transfer is discarded.
REQ-022 Priority SHALL be rst_i > flush_i > stall_i > normal transfer.
REQ-023 Simultaneous input and output transfer SHALL keep count_o unchanged and preserve beat order.
REQ-024 Beats SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush_i or rst_i.

Reset
REQ-025 With rst_i=1 at an edge: valid_o=0, ctrl_o=0, data_o=0, count_o=0, skid entry invalid and zero.
REQ-026 ready_o SHALL be 0 while rst_i=1 and SHALL equal !stall_i in the first cycle after reset.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: a second (skid) entry SHALL exist; ready_o = !stall_i && (count_o<2) and SHALL NOT depend combinationally on ready_i; full throughput SHALL be sustained under back-pressure.
REQ-028 Macro undefined: single entry; ready_o = !stall_i && (!valid_o || ready_i); count_o[1] SHALL be tied to 0.

Structure
REQ-029 Package pipe_pkg SHALL hold DATA_W/CTRL_W defaults and WB/M/EX field offsets within ctrl.
REQ-030 The skid entry SHALL be a sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-031 Reset then valid_i=1, ctrl_i=8'hA5, data_i=1 with ready_i=1 -> next cycle valid_o=1, ctrl_o=8'hA5, data_o=1, count_o=1.
REQ-032 Stream beats D1..D4, ready_i=0 for two cycles (skid on) -> count_o reaches 2, ready_o=0, D1 stable; on release D1..D4 emerge in order, no gaps.
REQ-033 stall_i=1 with valid_i=1, data_i=7 -> ready_o=0, beat 7 never appears; held beat still drains when ready_i=1.
REQ-034 count_o=2, flush_i=1, valid_i=1 same cycle -> next cycle valid_o=0, ctrl_o=0, count_o=0; the input beat is lost.
REQ-035 rst_i=1 asserted mid-stream with count_o=2 -> next cycle all outputs zero, count_o=0; no prior beat reappears.
REQ-036 Skid off, valid_o=1, ready_i toggles 0/1 -> ready_o mirrors ready_i combinationally; one beat per ready_i=1 cycle.
